// File: rtl/pc_gen_pkg.sv
// Shared constants, FSM encodings and redirect kinds for the IF-stage PC generator.
package pc_gen_pkg;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic BRANCH_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    PCG_OFF  = 2'd0,
    PCG_BOOT = 2'd1,
    PCG_RUN  = 2'd2
  } pcg_state_t;

  typedef enum logic {
    REDIR_BRANCH = 1'b0,
    REDIR_FLUSH  = 1'b1
  } redir_kind_t;

endpackage

// File: rtl/pc_gen_if.sv
// Control/redirect inputs and fetch outputs of the PC generator, bundled as one port.
interface pc_gen_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned STALL_W = 6
);

  logic [STALL_W-1:0] ctrl_stall;
  logic               flush;
  logic [ADDR_W-1:0]  flush_addr;
  logic               be;
  logic [ADDR_W-1:0]  baddr;
  logic               imem_ready;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redir_pend;
  logic               misalign;

  // master: the PC generator itself
  modport master (
    input  ctrl_stall, flush, flush_addr, be, baddr, imem_ready,
    output pc, ce, redir_pend, misalign
  );

  // slave: the pipeline/memory side feeding it
  modport slave (
    output ctrl_stall, flush, flush_addr, be, baddr, imem_ready,
    input  pc, ce, redir_pend, misalign
  );

endinterface

// File: rtl/pc_redir_buf.sv
// Holds one redirect that arrived while fetch could not advance; flushes outrank branches.
module pc_redir_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              adv,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              be,
  input  logic [ADDR_W-1:0] baddr,
  output logic              pend,
  output logic [ADDR_W-1:0] tgt
);

  redir_kind_t kind;

  // An advancing edge always consumes (or finds empty) the buffer; live redirects are muxed in the top.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pend <= 1'b0;
      kind <= REDIR_BRANCH;
      tgt  <= '0;
    end else if (adv) begin
      pend <= 1'b0;
    end else if (ce == CHIP_ENABLE) begin
      if (flush) begin
        pend <= 1'b1;
        kind <= REDIR_FLUSH;
        tgt  <= flush_addr;
      end else if ((be == BRANCH_ENABLE) && !(pend && (kind == REDIR_FLUSH))) begin
        pend <= 1'b1;
        kind <= REDIR_BRANCH;
        tgt  <= baddr;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: boot FSM, next-PC priority mux and fetch-enable generation.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       STALL_W   = 6
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);

  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

  pcg_state_t         state, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, nxt_pc, pend_tgt;
  logic               ce_q, ce_d, mis_q, mis_d;
  logic               pend, adv, take;
  logic [STALL_W-1:0] stall_vec;
  logic               unused_stall_hi;

  // Only the IF stall bit matters here; the rest of the vector belongs to later stages.
  assign stall_vec       = bus.ctrl_stall;
  assign unused_stall_hi = ^stall_vec;
  assign adv = (ce_q == CHIP_ENABLE) && (stall_vec[0] == STALL_DISABLE) && bus.imem_ready;

  pc_redir_buf #(.ADDR_W(ADDR_W)) u_redir_buf (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce_q),
    .adv        (adv),
    .flush      (bus.flush),
    .flush_addr (bus.flush_addr),
    .be         (bus.be),
    .baddr      (bus.baddr),
    .pend       (pend),
    .tgt        (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= PCG_OFF;
      pc_q  <= RESET_VEC;
      ce_q  <= CHIP_DISABLE;
      mis_q <= 1'b0;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
      ce_q  <= ce_d;
      mis_q <= mis_d;
    end
  end

  // A live be is intentionally lost when a buffered redirect is consumed: it came from a squashed path.
  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    ce_d    = ce_q;
    mis_d   = mis_q;
    nxt_pc  = pc_q + STEP_INC;
    take    = 1'b0;

    if (bus.flush) begin
      nxt_pc = bus.flush_addr;
      take   = 1'b1;
    end else if (pend) begin
      nxt_pc = pend_tgt;
      take   = 1'b1;
    end else if (bus.be == BRANCH_ENABLE) begin
      nxt_pc = bus.baddr;
      take   = 1'b1;
    end

    case (state)
      PCG_OFF: begin
        state_d = PCG_BOOT;
        ce_d    = CHIP_ENABLE;
        pc_d    = RESET_VEC;
        mis_d   = 1'b0;
      end
      PCG_BOOT, PCG_RUN: begin
        ce_d = CHIP_ENABLE;
        if (adv) begin
          state_d = PCG_RUN;
          pc_d    = nxt_pc;
          if (take) mis_d = |(nxt_pc & STEP_MASK);
        end
      end
      default: begin
        state_d = PCG_OFF;
        ce_d    = CHIP_DISABLE;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.ce         = ce_q;
  assign bus.redir_pend = pend;
  assign bus.misalign   = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scenario bench for pc_gen: 32-bit instance for redirect behaviour, 8-bit instance for wrap.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus32 ();
  pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus8 ();

  pc_gen #(.ADDR_W(32), .STEP(4), .RESET_VEC(32'h0000_0000), .STALL_W(6)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  pc_gen #(.ADDR_W(8), .STEP(4), .RESET_VEC(8'h00), .STALL_W(6)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, input logic ce, input logic pend, input logic mis);
    exp_t e;
    e.pc = pc; e.ce = ce; e.pend = pend; e.mis = mis;
    return e;
  endfunction

  function automatic exp_t sample32();
    return mk(bus32.pc, bus32.ce, bus32.redir_pend, bus32.misalign);
  endfunction

  function automatic exp_t sample8();
    return mk(32'(bus8.pc), bus8.ce, bus8.redir_pend, bus8.misalign);
  endfunction

  task automatic idle32();
    bus32.ctrl_stall = 6'b0; bus32.flush = 1'b0; bus32.flush_addr = '0;
    bus32.be = 1'b0; bus32.baddr = '0; bus32.imem_ready = 1'b1;
  endtask

  task automatic idle8();
    bus8.ctrl_stall = 6'b0; bus8.flush = 1'b0; bus8.flush_addr = '0;
    bus8.be = 1'b0; bus8.baddr = '0; bus8.imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, act;
    logic [31:0] epc;
    for (int i = 0; i < 6; i++) begin
      idle32();
      rst = (i < 3) ? 1'b0 : 1'b1;
      epc = (i < 4) ? 32'h0 : (i == 4) ? 32'h4 : 32'h8;
      sb.push_back(mk(epc, (i >= 3), 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_branch_run();
    exp_t e, act;
    logic [31:0] epc;
    for (int i = 0; i < 4; i++) begin
      idle32();
      if (i == 2) begin bus32.be = 1'b1; bus32.baddr = 32'h100; end
      case (i)
        0: epc = 32'hC;
        1: epc = 32'h10;
        2: epc = 32'h100;
        default: epc = 32'h104;
      endcase
      sb.push_back(mk(epc, 1'b1, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL branch_run cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_branch_stall();
    exp_t e, act;
    logic [31:0] epc;
    for (int i = 0; i < 5; i++) begin
      idle32();
      if (i < 3) bus32.ctrl_stall = 6'b000001;
      if (i == 0) begin bus32.be = 1'b1; bus32.baddr = 32'h200; end
      epc = (i < 3) ? 32'h104 : (i == 3) ? 32'h200 : 32'h204;
      sb.push_back(mk(epc, 1'b1, (i < 3), 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL branch_stall cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_flush_over_branch();
    exp_t e, act;
    logic [31:0] epc;
    for (int i = 0; i < 5; i++) begin
      idle32();
      if (i < 3) bus32.ctrl_stall = 6'b000001;
      case (i)
        0: begin bus32.be = 1'b1; bus32.baddr = 32'h300; end
        1: begin bus32.flush = 1'b1; bus32.flush_addr = 32'h80; end
        2: begin bus32.be = 1'b1; bus32.baddr = 32'h400; end
        default: ;
      endcase
      epc = (i < 3) ? 32'h204 : (i == 3) ? 32'h80 : 32'h84;
      sb.push_back(mk(epc, 1'b1, (i < 3), 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL flush_over_branch cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e, act;
    logic [31:0] epc;
    logic        epend;
    for (int i = 0; i < 7; i++) begin
      idle32();
      epend = 1'b0;
      case (i)
        0: begin bus32.ctrl_stall = 6'b000001; bus32.be = 1'b1; bus32.baddr = 32'h500; epc = 32'h84; epend = 1'b1; end
        1: begin bus32.be = 1'b1; bus32.baddr = 32'h600; epc = 32'h500; end
        2: epc = 32'h504;
        3: begin bus32.ctrl_stall = 6'b000001; bus32.be = 1'b1; bus32.baddr = 32'h700; epc = 32'h504; epend = 1'b1; end
        4: begin bus32.flush = 1'b1; bus32.flush_addr = 32'h900; epc = 32'h900; end
        5: begin bus32.ctrl_stall = 6'b111110; epc = 32'h904; end
        default: epc = 32'h908;
      endcase
      sb.push_back(mk(epc, 1'b1, epend, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL priority cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_handshake_wrap();
    exp_t e, act;
    logic [31:0] epc;
    for (int i = 0; i < 6; i++) begin
      idle8();
      if (i == 0) begin bus8.be = 1'b1; bus8.baddr = 8'hF8; end
      if (i == 2 || i == 3) bus8.imem_ready = 1'b0;
      case (i)
        0: epc = 32'hF8;
        1, 2, 3: epc = 32'hFC;
        4: epc = 32'h00;
        default: epc = 32'h04;
      endcase
      sb.push_back(mk(epc, 1'b1, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample8(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL handshake_wrap cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  task automatic test_misalign_reset();
    exp_t e, act;
    for (int i = 0; i < 8; i++) begin
      idle32();
      rst = 1'b1;
      case (i)
        0: begin bus32.be = 1'b1; bus32.baddr = 32'h102; e = mk(32'h102, 1'b1, 1'b0, 1'b1); end
        1: e = mk(32'h106, 1'b1, 1'b0, 1'b1);
        2: begin bus32.be = 1'b1; bus32.baddr = 32'h200; e = mk(32'h200, 1'b1, 1'b0, 1'b0); end
        3: begin bus32.be = 1'b1; bus32.baddr = 32'h20A; e = mk(32'h20A, 1'b1, 1'b0, 1'b1); end
        4: begin bus32.ctrl_stall = 6'b000001; bus32.be = 1'b1; bus32.baddr = 32'h303;
                 e = mk(32'h20A, 1'b1, 1'b1, 1'b1); end
        5: begin rst = 1'b0; bus32.ctrl_stall = 6'b000001; e = mk(32'h0, 1'b0, 1'b0, 1'b0); end
        6: e = mk(32'h0, 1'b1, 1'b0, 1'b0);
        default: e = mk(32'h4, 1'b1, 1'b0, 1'b0);
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); act = sample32(); n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL misalign_reset cyc%0d: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b",
                 i, act.pc, act.ce, act.pend, act.mis, e.pc, e.ce, e.pend, e.mis);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_checks = 0;
    n_fail = 0;
    idle32();
    idle8();
    #1;
    test_reset();
    test_branch_run();
    test_branch_stall();
    test_flush_over_branch();
    test_priority();
    test_handshake_wrap();
    test_misalign_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the five-stage pipeline's IF stage; the next generation of the team's PC block.
- Adds configurable address width, step and reset vector, flush redirects with priority over branches, and buffering of redirects that arrive while fetch is stalled (no longer dropped).
- Adds an instruction-memory ready handshake.
- Drives the IF-stage fetch address and chip enable.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- STEP, 4, sequential increment in bytes (power of two).
- RESET_VEC, 32'h0000_0000, PC value while disabled and after reset.
- STALL_W, 6, width of the ctrl_stall vector; only bit 0 (IF stall) is used.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-low reset.
- ctrl_stall  in  STALL_W  stall vector from the stall controller; bit 0 = 1 holds the PC.
- flush  in  1  exception/flush redirect request, highest priority.
- flush_addr  in  ADDR_W  flush target.
- be  in  1  branch-enable redirect from ID.
- baddr  in  ADDR_W  branch target.
- imem_ready  in  1  instruction memory accepts the current pc this cycle.
- pc  out  ADDR_W  fetch address.
- ce  out  1  instruction-memory chip enable.
- redir_pend  out  1  a buffered redirect is waiting.
- misalign  out  1  the last redirect taken had nonzero low log2(STEP) bits; sticky until the next redirect.

Behaviour:
- Reset (rst=0 at a posedge):
  - ce=0, pc=RESET_VEC, redir_pend=0, misalign=0, pending target cleared, FSM to S_OFF.
  - This applies mid-operation: a pending redirect is discarded.
- FSM states:
  - S_OFF: ce=0, pc held at RESET_VEC, all redirects ignored. Goes to S_BOOT on the first posedge with rst=1.
  - S_BOOT: ce=1, pc=RESET_VEC (the first fetch). Goes to S_RUN once adv=1. Redirects arriving in this state are buffered.
  - S_RUN: normal operation.
- adv = ce & ~ctrl_stall[0] & imem_ready. The PC only changes on posedges where adv=1.
- Next-PC selection when adv=1, highest priority first:
  1. flush → flush_addr.
  2. Pending buffered redirect → its target.
  3. be → baddr.
  4. Otherwise pc+STEP.
- Live flush beats a pending branch. A live be in the same cycle as a consumed pending redirect is dropped; that branch came from a squashed path.
- Buffering when adv=0 and ce=1:
  - flush: stored; redir_pend=1 next cycle; overwrites any pending branch.
  - be with no pending flush: stored.
  - be while a flush is pending: ignored.
  - A later be overwrites an earlier pending be.
- Pending target consumed on the first adv posedge; redir_pend clears the same edge.
- Arithmetic: pc+STEP wraps modulo 2^ADDR_W; no overflow flag. Redirect targets are used verbatim (no alignment masking). misalign is set when target[log2(STEP)-1:0] != 0.
- Latency: redirect sampled at edge N appears on pc after edge N (one cycle) if adv=1 at N. Otherwise it appears after the first later edge with adv=1.
- ctrl_stall bits other than 0 are ignored.
- imem_ready=0 behaves exactly like a stall.

Decomposition:
- Shared package/header (existing define file) holds:
  - RST_ENABLE (1'b0 for this active-low reset), CHIP_ENABLE/CHIP_DISABLE, STALL_ENABLE/DISABLE, BRANCH_ENABLE.
  - FSM state encodings PCG_OFF/PCG_BOOT/PCG_RUN.
- One natural sub-module: pc_redir_buf, holding the pending target register, its kind (flush/branch), and the overwrite/priority rules. The top contains the FSM and next-PC mux.

Test Plan:
- Reset release: rst=0 for 3 cycles, then 1, imem_ready=1, no stall → ce 0→1 one cycle after release; pc sequence 0x0, 0x4, 0x8.
- Branch while running: at pc=0x10 assert be, baddr=0x100 for one cycle → next pc=0x100, then 0x104; redir_pend stays 0.
- Branch during stall: ctrl_stall[0]=1 for 3 cycles with be, baddr=0x200 pulsed in the first → pc held, redir_pend=1; on stall release pc=0x200, redir_pend=0.
- Flush over pending branch: stall, pulse be=0x300, then flush=0x80 while still stalled, then a later be=0x400 → on release pc=0x80; both branches discarded.
- Handshake and wrap: ADDR_W=8, pc=0xFC, imem_ready low 2 cycles → pc holds 0xFC; then advances to 0x00.
- Misalign and reset mid-op: be with baddr=0x102 → pc=0x102, misalign=1; pending redirect plus rst=0 → pc=RESET_VEC, redir_pend=0, misalign=0, ce=0.
